// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Results are computed at launch into shadow registers and committed after the modelled latency.
module mdu_seq #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rd_data
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_sh_hi;
    logic [WIDTH-1:0]   r_sh_lo;

    logic               w_launch;
    logic [2*WIDTH-1:0] w_as;
    logic [2*WIDTH-1:0] w_bs;
    logic [2*WIDTH-1:0] w_au;
    logic [2*WIDTH-1:0] w_bu;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_b_zero;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_sdiv;
    logic [WIDTH-1:0]   w_udiv;
    logic [WIDTH-1:0]   w_sq;
    logic [WIDTH-1:0]   w_sr;
    logic [WIDTH-1:0]   w_q_s;
    logic [WIDTH-1:0]   w_r_s;
    logic [WIDTH-1:0]   w_q_u;
    logic [WIDTH-1:0]   w_r_u;

    assign w_launch = (r_state == S_IDLE) && start && !cancel;

    assign w_as     = {{WIDTH{a[WIDTH-1]}}, a};
    assign w_bs     = {{WIDTH{b[WIDTH-1]}}, b};
    assign w_au     = {{WIDTH{1'b0}}, a};
    assign w_bu     = {{WIDTH{1'b0}}, b};
    assign w_prod_s = w_as * w_bs;
    assign w_prod_u = w_au * w_bu;

    // Signed divide on magnitudes; the most negative dividend wraps to its own
    // magnitude, which yields the required overflow quotient naturally.
    assign w_a_neg  = a[WIDTH-1];
    assign w_b_neg  = b[WIDTH-1];
    assign w_b_zero = (b == '0);
    assign w_abs_a  = w_a_neg ? (~a + ONE) : a;
    assign w_abs_b  = w_b_neg ? (~b + ONE) : b;
    assign w_sdiv   = w_b_zero ? ONE : w_abs_b;
    assign w_udiv   = w_b_zero ? ONE : b;
    assign w_sq     = w_abs_a / w_sdiv;
    assign w_sr     = w_abs_a % w_sdiv;
    assign w_q_s    = (w_a_neg ^ w_b_neg) ? (~w_sq + ONE) : w_sq;
    assign w_r_s    = w_a_neg ? (~w_sr + ONE) : w_sr;
    assign w_q_u    = a / w_udiv;
    assign w_r_u    = a % w_udiv;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_sh_hi <= '0;
            r_sh_lo <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                r_sh_hi <= (op == OP_MULT) ? w_prod_s[2*WIDTH-1:WIDTH]
                                                           : w_prod_u[2*WIDTH-1:WIDTH];
                                r_sh_lo <= (op == OP_MULT) ? w_prod_s[WIDTH-1:0]
                                                           : w_prod_u[WIDTH-1:0];
                                r_cnt   <= MULT_LOAD;
                                r_busy  <= 1'b1;
                                r_state <= S_RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                // Divide by zero recommits the current HI/LO
                                if (w_b_zero) begin
                                    r_sh_hi <= r_hi;
                                    r_sh_lo <= r_lo;
                                end else begin
                                    r_sh_hi <= (op == OP_DIV) ? w_r_s : w_r_u;
                                    r_sh_lo <= (op == OP_DIV) ? w_q_s : w_q_u;
                                end
                                r_cnt   <= DIV_LOAD;
                                r_busy  <= 1'b1;
                                r_state <= S_RUN;
                            end
                            OP_MTHI: r_hi <= a;
                            OP_MTLO: r_lo <= a;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (r_cnt == '0) begin
                        r_hi    <= r_sh_hi;
                        r_lo    <= r_sh_lo;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        case (op)
            OP_MFHI: rd_data = r_hi;
            OP_MFLO: rd_data = r_lo;
            default: ;
        endcase
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed-vector bench for mdu_seq: default latencies plus a 1-cycle instance.
// Inputs change on negedges; outputs are sampled on negedges.
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        cancel;
    logic        en1;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd;
    logic        busy1;
    logic [31:0] hi1;
    logic [31:0] lo1;
    logic [31:0] rd1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mdu_seq #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .cancel(cancel),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo), .rd_data(rd)
    );

    mdu_seq #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .start(start & en1), .op(op), .cancel(cancel),
        .a(a), .b(b), .busy(busy1), .hi(hi1), .lo(lo1), .rd_data(rd1)
    );

    // Called at a negedge: presents one op for one edge, then counts busy cycles.
    task automatic run_op(input logic [3:0] o, input logic [31:0] aa,
                          input logic [31:0] bb, input logic c,
                          output int cyc, output int cyc1,
                          output logic [31:0] ph, output logic [31:0] pl);
        start  = 1'b1;
        op     = o;
        a      = aa;
        b      = bb;
        cancel = c;
        @(negedge clk);
        start  = 1'b0;
        op     = 4'd0;
        cancel = 1'b0;
        ph     = hi;
        pl     = lo;
        cyc    = 0;
        cyc1   = 0;
        for (int k = 0; k < 40 && (busy || busy1); k++) begin
            if (busy) cyc++;
            if (busy1) cyc1++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #12;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", busy); end
        n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL rst_hi got %h exp 0", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_err++; $display("FAIL rst_lo got %h exp 0", lo); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mtx;
        int c0, c1;
        logic [31:0] ph, pl;
        run_op(4'd7, 32'h11, 32'h0, 1'b0, c0, c1, ph, pl);
        n_cmp++; if (c0 !== 0) begin n_err++; $display("FAIL mthi_busy got %0d exp 0", c0); end
        run_op(4'd8, 32'h22, 32'h0, 1'b0, c0, c1, ph, pl);
        n_cmp++; if (hi !== 32'h11) begin n_err++; $display("FAIL mthi got %h exp 11", hi); end
        n_cmp++; if (lo !== 32'h22) begin n_err++; $display("FAIL mtlo got %h exp 22", lo); end
    endtask

    task automatic test_reset_mid_run;
        int c0, c1;
        logic [31:0] ph, pl;
        start = 1'b1; op = 4'd1; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_pre got %b exp 1", busy); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got %b exp 0", busy); end
        n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL mid_hi got %h exp 0", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_err++; $display("FAIL mid_lo got %h exp 0", lo); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_op(4'd1, 32'd3, 32'd4, 1'b0, c0, c1, ph, pl);
        n_cmp++; if (c0 !== 5) begin n_err++; $display("FAIL post_rst_cyc got %0d exp 5", c0); end
        n_cmp++; if (lo !== 32'd12) begin n_err++; $display("FAIL post_rst_lo got %h exp c", lo); end
        n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL post_rst_hi got %h exp 0", hi); end
    endtask

    task automatic test_mult;
        int c0, c1;
        logic [31:0] ph, pl;
        run_op(4'd1, 32'hFFFFFFFF, 32'h2, 1'b0, c0, c1, ph, pl);
        n_cmp++; if (ph !== 32'h0) begin n_err++; $display("FAIL mult_hold_hi got %h exp 0", ph); end
        n_cmp++; if (pl !== 32'd12) begin n_err++; $display("FAIL mult_hold_lo got %h exp c", pl); end
        n_cmp++; if (c0 !== 5) begin n_err++; $display("FAIL mult_cyc got %0d exp 5", c0); end
        n_cmp++; if (c1 !== 1) begin n_err++; $display("FAIL mult_cyc1 got %0d exp 1", c1); end
        n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mult_hi got %h exp ffffffff", hi); end
        n_cmp++; if (lo !== 32'hFFFFFFFE) begin n_err++; $display("FAIL mult_lo got %h exp fffffffe", lo); end
        n_cmp++; if (hi1 !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mult_hi1 got %h exp ffffffff", hi1); end
        n_cmp++; if (lo1 !== 32'hFFFFFFFE) begin n_err++; $display("FAIL mult_lo1 got %h exp fffffffe", lo1); end
        run_op(4'd2, 32'hFFFFFFFF, 32'h2, 1'b0, c0, c1, ph, pl);
        n_cmp++; if (c0 !== 5) begin n_err++; $display("FAIL multu_cyc got %0d exp 5", c0); end
        n_cmp++; if (hi !== 32'h1) begin n_err++; $display("FAIL multu_hi got %h exp 1", hi); end
        n_cmp++; if (lo !== 32'hFFFFFFFE) begin n_err++; $display("FAIL multu_lo got %h exp fffffffe", lo); end
        n_cmp++; if (hi1 !== 32'h1) begin n_err++; $display("FAIL multu_hi1 got %h exp 1", hi1); end
    endtask

    task automatic test_div;
        int c0, c1;
        logic [31:0] ph, pl;
        run_op(4'd3, 32'hFFFFFFF9, 32'h2, 1'b0, c0, c1, ph, pl);
        n_cmp++; if (ph !== 32'h1) begin n_err++; $display("FAIL div_hold_hi got %h exp 1", ph); end
        n_cmp++; if (c0 !== 10) begin n_err++; $display("FAIL div_cyc got %0d exp 10", c0); end
        n_cmp++; if (c1 !== 1) begin n_err++; $display("FAIL div_cyc1 got %0d exp 1", c1); end
        n_cmp++; if (lo !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_lo got %h exp fffffffd", lo); end
        n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div_hi got %h exp ffffffff", hi); end
        n_cmp++; if (lo1 !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_lo1 got %h exp fffffffd", lo1); end
        run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, c0, c1, ph, pl);
        n_cmp++; if (lo !== 32'h80000000) begin n_err++; $display("FAIL divovf_lo got %h exp 80000000", lo); end
        n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL divovf_hi got %h exp 0", hi); end
        run_op(4'd4, 32'd100, 32'd7, 1'b0, c0, c1, ph, pl);
        n_cmp++; if (lo !== 32'd14) begin n_err++; $display("FAIL divu_lo got %h exp e", lo); end
        n_cmp++; if (hi !== 32'd2) begin n_err++; $display("FAIL divu_hi got %h exp 2", hi); end
        run_op(4'd4, 32'hFFFFFFF9, 32'h2, 1'b0, c0, c1, ph, pl);
        n_cmp++; if (lo !== 32'h7FFFFFFC) begin n_err++; $display("FAIL divu_big_lo got %h exp 7ffffffc", lo); end
        n_cmp++; if (hi !== 32'h1) begin n_err++; $display("FAIL divu_big_hi got %h exp 1", hi); end
    endtask

    task automatic test_div_zero;
        int c0, c1;
        logic [31:0] ph, pl;
        run_op(4'd7, 32'h11, 32'h0, 1'b0, c0, c1, ph, pl);
        run_op(4'd8, 32'h22, 32'h0, 1'b0, c0, c1, ph, pl);
        run_op(4'd4, 32'd50, 32'h0, 1'b0, c0, c1, ph, pl);
        n_cmp++; if (c0 !== 10) begin n_err++; $display("FAIL dz_cyc got %0d exp 10", c0); end
        n_cmp++; if (hi !== 32'h11) begin n_err++; $display("FAIL dz_hi got %h exp 11", hi); end
        n_cmp++; if (lo !== 32'h22) begin n_err++; $display("FAIL dz_lo got %h exp 22", lo); end
        n_cmp++; if (lo1 !== 32'h22) begin n_err++; $display("FAIL dz_lo1 got %h exp 22", lo1); end
        run_op(4'd3, 32'hFFFFFFF0, 32'h0, 1'b0, c0, c1, ph, pl);
        n_cmp++; if (c0 !== 10) begin n_err++; $display("FAIL dzs_cyc got %0d exp 10", c0); end
        n_cmp++; if (hi !== 32'h11) begin n_err++; $display("FAIL dzs_hi got %h exp 11", hi); end
        n_cmp++; if (lo !== 32'h22) begin n_err++; $display("FAIL dzs_lo got %h exp 22", lo); end
    endtask

    task automatic test_cancel;
        int c0, c1;
        logic [31:0] ph, pl;
        run_op(4'd1, 32'd7, 32'd9, 1'b1, c0, c1, ph, pl);
        n_cmp++; if (c0 !== 0) begin n_err++; $display("FAIL cancel_busy got %0d exp 0", c0); end
        n_cmp++; if (c1 !== 0) begin n_err++; $display("FAIL cancel_busy1 got %0d exp 0", c1); end
        n_cmp++; if (lo !== 32'h22) begin n_err++; $display("FAIL cancel_lo got %h exp 22", lo); end
        run_op(4'd7, 32'h99, 32'h0, 1'b1, c0, c1, ph, pl);
        n_cmp++; if (hi !== 32'h11) begin n_err++; $display("FAIL cancel_mthi got %h exp 11", hi); end
        run_op(4'd8, 32'h98, 32'h0, 1'b1, c0, c1, ph, pl);
        n_cmp++; if (lo !== 32'h22) begin n_err++; $display("FAIL cancel_mtlo got %h exp 22", lo); end
    endtask

    task automatic test_mfhi;
        op = 4'd5; #1;
        n_cmp++; if (rd !== 32'h11) begin n_err++; $display("FAIL mfhi got %h exp 11", rd); end
        op = 4'd6; #1;
        n_cmp++; if (rd !== 32'h22) begin n_err++; $display("FAIL mflo got %h exp 22", rd); end
        op = 4'd1; #1;
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL rd_other got %h exp 0", rd); end
        op = 4'd12; #1;
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL rd_none got %h exp 0", rd); end
        op = 4'd0;
        @(negedge clk);
    endtask

    task automatic test_ignore;
        en1 = 1'b0;
        start = 1'b1; op = 4'd1; a = 32'd3; b = 32'd5;
        @(negedge clk);
        op = 4'd8; a = 32'h55; b = 32'h0;
        @(negedge clk);
        op = 4'd7; a = 32'h66;
        @(negedge clk);
        start = 1'b0; op = 4'd0; a = 32'hDEAD;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ign_busy got %b exp 1", busy); end
        n_cmp++; if (lo !== 32'h22) begin n_err++; $display("FAIL ign_lo_hold got %h exp 22", lo); end
        for (int k = 0; k < 40 && busy; k++) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ign_timeout busy got %b exp 0", busy); end
        n_cmp++; if (lo !== 32'd15) begin n_err++; $display("FAIL ign_lo got %h exp f", lo); end
        n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL ign_hi got %h exp 0", hi); end
        en1 = 1'b1;
    endtask

    task automatic test_back_to_back;
        int c0, c1;
        logic [31:0] ph, pl;
        run_op(4'd2, 32'd6, 32'd7, 1'b0, c0, c1, ph, pl);
        n_cmp++; if (lo !== 32'd42) begin n_err++; $display("FAIL b2b_lo1 got %h exp 2a", lo); end
        run_op(4'd4, 32'd20, 32'd6, 1'b0, c0, c1, ph, pl);
        n_cmp++; if (pl !== 32'd42) begin n_err++; $display("FAIL b2b_hold got %h exp 2a", pl); end
        n_cmp++; if (c0 !== 10) begin n_err++; $display("FAIL b2b_cyc got %0d exp 10", c0); end
        n_cmp++; if (lo !== 32'd3) begin n_err++; $display("FAIL b2b_lo got %h exp 3", lo); end
        n_cmp++; if (hi !== 32'd2) begin n_err++; $display("FAIL b2b_hi got %h exp 2", hi); end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; cancel = 1'b0; en1 = 1'b1;
        op = 4'd0; a = 32'h0; b = 32'h0;
        test_reset;
        test_mtx;
        test_reset_mid_run;
        test_mult;
        test_div;
        test_div_zero;
        test_cancel;
        test_mfhi;
        test_ignore;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Parametrised, multi-cycle multiply/divide unit for the E stage of the P7-class pipeline, with HI/LO registers.
- Accepts decoded MDU operations (mult, multu, div, divu, mfhi, mflo, mthi, mtlo) from the control unit.
- Models configurable multiply and divide latency and drives a busy flag for the hazard unit.
- Supports exception-cancel of a launching operation so HI/LO state stays precise across CP0 exceptions.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).
- CNT_W, 8, latency counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  valid MDU instruction present in E this cycle.
- op  in  4  MDUOp encoding: 0 default/none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 treated as none.
- cancel  in  1  exception/flush: suppresses any start in the same cycle.
- a  in  WIDTH  rs operand.
- b  in  WIDTH  rt operand.
- busy  out  1  registered; 1 while a mult/div is in flight.
- hi  out  WIDTH  current HI register.
- lo  out  WIDTH  current LO register.
- rd_data  out  WIDTH  combinational read result: op==5 gives hi, op==6 gives lo, otherwise 0.

Behaviour:
- Reset (asynchronous, whenever reset==0):
  - State goes to IDLE; busy=0; hi=0; lo=0; counter=0; shadow results=0.
  - Any in-flight operation is discarded.
- States:
  - IDLE: accepts operations.
  - RUN: operation in flight, counter decrementing.
- Launch is a posedge with state==IDLE, start=1, cancel=0.
- Launch with op 1-4:
  - Compute the full result into shadow registers (sh_hi, sh_lo).
  - Load counter with MULT_CYCLES-1 or DIV_CYCLES-1.
  - Set busy=1 and go to RUN.
- Launch with op 7/8: write a to hi/lo at that edge; no busy.
- Op 5/6: no state change; rd_data is valid in the same cycle.
- RUN:
  - Each posedge decrements the counter.
  - At the edge where the counter is 0: commit hi<=sh_hi, lo<=sh_lo, busy<=0, go to IDLE.
  - busy is high for exactly N cycles after the launch edge (N = the relevant *_CYCLES).
  - hi/lo keep their old values until the commit edge.
- start while busy: ignored entirely, for all ops including mthi/mtlo. The hazard unit stalls D on busy, so this is an illegal-use case. The bench checks only that state is not corrupted.
- cancel=1: blocks launch and mthi/mtlo writes in that cycle. An operation already in RUN is not aborted and completes normally.
- Arithmetic:
  - mult: signed WIDTHxWIDTH to 2*WIDTH; hi = upper half, lo = lower half.
  - multu: unsigned, same split.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - div overflow (a = -2^(WIDTH-1), b = -1): lo = 0x80000000 (for WIDTH=32), hi = 0.
  - divu: unsigned quotient/remainder.
  - Divide by zero (b==0, div or divu): still occupies DIV_CYCLES; hi/lo are left unchanged at commit.
- Operands are sampled only at the launch edge; later changes on a/b have no effect.
- Back-to-back: a new launch is possible on the edge after the commit edge (busy=0 for at least one cycle).

Test Plan:
- Reset mid-RUN: launch mult, assert reset=0 on cycle 2 -> busy=0, hi=0, lo=0 immediately (asynchronous). After release, a launch works normally.
- Signed/unsigned mult: a=0xFFFFFFFF, b=0x00000002.
  - op=1 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - op=2 -> hi=0x00000001, lo=0xFFFFFFFE.
  - Before the commit edge, hi/lo hold their prior values.
- Signed div: a=0xFFFFFFF9 (-7), b=2, op=3 -> 10 busy cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: preload hi=0x11, lo=0x22 via mthi/mtlo, then op=4, b=0 -> busy for 10 cycles, then hi=0x11, lo=0x22.
- Cancel and ignore:
  - start=1, op=1, cancel=1 -> busy stays 0, hi/lo unchanged.
  - start=1, op=7, cancel=1 -> hi unchanged.
  - During RUN, start op=8 with a=0x55 -> lo equals the committed mult result, not 0x55.
- mfhi/mflo plus parameter sweep:
  - op=5/6 -> rd_data equals hi/lo combinationally.
  - Rerun the mult and div checks with MULT_CYCLES=1, DIV_CYCLES=1 -> busy high for exactly 1 cycle.
